// File: rtl/rd_scoreboard_pkg.sv
// Shared definitions for the register-busy scoreboard.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the RV32I major opcodes that the use decoder and the bench both need.
package rd_scoreboard_pkg;

   localparam int unsigned OPCODE_W = 7;

   // RV32I major opcodes, instruction bits [6:0]
   typedef enum logic [OPCODE_W-1:0] {
      R_TYPE      = 7'b0110011,
      I_TYPE      = 7'b0010011,
      LOAD_TYPE   = 7'b0000011,
      STORE_TYPE  = 7'b0100011,
      BRANCH_TYPE = 7'b1100011,
      J_TYPE      = 7'b1101111,
      JALR_TYPE   = 7'b1100111,
      LUI_TYPE    = 7'b0110111,
      AUIPC_TYPE  = 7'b0010111
   } opcode_e;

endpackage

// File: rtl/rd_scoreboard_decode.sv
// Opcode -> register-use decoder (rd write, rs1 read, rs2 read).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   i_opcode     instruction opcode [6:0]
//   i_rd         destination index; a write to x0 is reported as no write
//   o_writes_rd  instruction produces a register result
//   o_uses_rs1   instruction reads rs1
//   o_uses_rs2   instruction reads rs2
module reg_use_decode
   import rd_scoreboard_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic [OPCODE_W-1:0] i_opcode,
   input  logic [ADDR_W-1:0]   i_rd,
   output logic                o_writes_rd,
   output logic                o_uses_rs1,
   output logic                o_uses_rs2
);

   logic w_dest;

   always_comb begin
      w_dest     = 1'b0;
      o_uses_rs1 = 1'b0;
      o_uses_rs2 = 1'b0;
      case (i_opcode)
         R_TYPE: begin
            w_dest     = 1'b1;
            o_uses_rs1 = 1'b1;
            o_uses_rs2 = 1'b1;
         end
         I_TYPE, LOAD_TYPE, JALR_TYPE: begin
            w_dest     = 1'b1;
            o_uses_rs1 = 1'b1;
         end
         STORE_TYPE, BRANCH_TYPE: begin
            o_uses_rs1 = 1'b1;
            o_uses_rs2 = 1'b1;
         end
         J_TYPE, LUI_TYPE, AUIPC_TYPE: begin
            w_dest     = 1'b1;
         end
         default: begin
            // unknown opcode: no register use, so it can never stall
            w_dest     = 1'b0;
         end
      endcase
   end

   // x0 is hardwired zero, so writing it creates no dependency
   assign o_writes_rd = w_dest & (i_rd != '0);

endmodule

// File: rtl/rd_scoreboard.sv
// Register-busy scoreboard at decode/issue: per-register pending-write counters, RAW/WAW stall.
// Latency: issue -> busy_vec 1 cycle; writeback -> stall release 1 cycle (no same-cycle bypass).
// Backpressure: stall (combinational) blocks issue; counters saturate at MAX_PENDING via stall.
//
// Ports:
//   clk, rst_n     core clock (rising edge), asynchronous active-low reset
//   flush          synchronous clear of all pending counts; beats issue and writeback
//   issue_valid    decode presents an instruction (opcode, rd, rs1, rs2)
//   wb_valid/wb_rd writeback retires one pending write to wb_rd (x0 ignored)
//   stall          issue blocked this cycle by a RAW or WAW hazard
//   issue_fire     instruction accepted this cycle
//   rd_enable      decoded instruction writes a non-zero rd
//   busy_vec       registered per-register busy flags, bit 0 always 0
//   wb_underflow   sticky: a writeback arrived for a register with nothing pending
module rd_scoreboard
   import rd_scoreboard_pkg::*;
#(
   parameter int NUM_REGS    = 32,
   parameter int ADDR_W      = 5,
   parameter int MAX_PENDING = 3,
   parameter int ALLOW_WAW   = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                issue_valid,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [ADDR_W-1:0]   rd,
   input  logic [ADDR_W-1:0]   rs1,
   input  logic [ADDR_W-1:0]   rs2,
   input  logic                wb_valid,
   input  logic [ADDR_W-1:0]   wb_rd,
   output logic                stall,
   output logic                issue_fire,
   output logic                rd_enable,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic                wb_underflow
);

   localparam int              CW      = $clog2(MAX_PENDING + 1);
   localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_PENDING);

   logic                w_writes_rd;
   logic                w_uses_rs1;
   logic                w_uses_rs2;
   logic                w_raw;
   logic                w_waw;
   logic                w_stall;
   logic                w_fire;
   logic                w_uf_hit;
   logic [CW-1:0]       w_cnt [NUM_REGS];
   logic [NUM_REGS-1:0] w_busy;
   logic                r_wb_underflow;

   reg_use_decode #(
      .ADDR_W      (ADDR_W)
   ) u_decode (
      .i_opcode    (opcode),
      .i_rd        (rd),
      .o_writes_rd (w_writes_rd),
      .o_uses_rs1  (w_uses_rs1),
      .o_uses_rs2  (w_uses_rs2)
   );

   // x0 is never tracked
   assign w_cnt[0]  = '0;
   assign w_busy[0] = 1'b0;

   for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
      logic [CW-1:0] r_cnt;
      logic          r_busy;
      logic          w_inc;
      logic          w_dec;
      logic [CW-1:0] w_nxt;

      assign w_inc = w_fire & w_writes_rd & (rd == ADDR_W'(gi));
      // a retire against an empty counter is an error, not a decrement
      assign w_dec = wb_valid & (wb_rd == ADDR_W'(gi)) & (r_cnt != '0);

      always_comb begin
         w_nxt = r_cnt;
         if (flush) begin
            w_nxt = '0;
         end else if (w_inc && !w_dec) begin
            w_nxt = r_cnt + CW'(1);
         end else if (w_dec && !w_inc) begin
            w_nxt = r_cnt - CW'(1);
         end
      end

      // busy flag is kept as its own flop so busy_vec comes straight off registers
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
         end else begin
            r_cnt  <= w_nxt;
            r_busy <= (w_nxt != '0);
         end
      end

      assign w_cnt[gi]  = r_cnt;
      assign w_busy[gi] = r_busy;
   end

   // hazards look only at registered state; a same-cycle writeback does not bypass
   assign w_raw = (w_uses_rs1 & w_busy[rs1]) | (w_uses_rs2 & w_busy[rs2]);
   assign w_waw = w_writes_rd &
                  ((ALLOW_WAW != 0) ? (w_cnt[rd] == CNT_MAX) : w_busy[rd]);

   assign w_stall = issue_valid & (w_raw | w_waw);
   assign w_fire  = issue_valid & ~w_stall & ~flush;

   // flush discards the writeback along with everything else, so it cannot underflow
   assign w_uf_hit = wb_valid & ~flush & (wb_rd != '0) & (w_cnt[wb_rd] == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wb_underflow <= 1'b0;
      end else if (w_uf_hit) begin
         r_wb_underflow <= 1'b1;
      end
   end

   assign stall        = w_stall;
   assign issue_fire   = w_fire;
   assign rd_enable    = w_writes_rd;
   assign busy_vec     = w_busy;
   assign wb_underflow = r_wb_underflow;

endmodule
